// File: rtl/apb_aud_pwm_pkg.sv
// aud_pwm_pkg: register offsets, CTRL/STAT bit indices and the CTRL register layout
// No ports; imported by the audio PWM interface, FIFO and top level.
package aud_pwm_pkg;
    localparam logic [2:0] OFF_CTRL = 3'd0;
    localparam logic [2:0] OFF_DIV  = 3'd1;
    localparam logic [2:0] OFF_DATA = 3'd2;
    localparam logic [2:0] OFF_STAT = 3'd3;
    localparam logic [2:0] OFF_DUTY = 3'd4;
    localparam int CTRL_EN       = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_FLUSH    = 2;
    localparam int CTRL_WMARK    = 8;
    localparam int STAT_UNDERRUN = 10;
    localparam logic [7:0] DUTY_RESET = 8'h80;
    typedef struct packed {
        logic [7:0] wmark;
        logic       irq_en;
        logic       en;
    } ctrl_reg_t;
endpackage

// File: rtl/apb_aud_pwm_if.sv
// apb_aud_pwm_if: APB bus bundle for the audio PWM completer
// Signals: paddr, pwdata, pwrite, psel, penable (master -> slave); prdata, pready, pslverr (slave -> master).
interface apb_aud_pwm_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pwrite;
    logic          psel;
    logic          penable;
    logic          pready;
    logic          pslverr;
    modport master (output paddr, pwdata, pwrite, psel, penable, input prdata, pready, pslverr);
    modport slave  (input paddr, pwdata, pwrite, psel, penable, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_aud_pwm_fifo.sv
// aud_pwm_fifo: synchronous 8-bit sample FIFO with push, pop, flush, level, full and empty
// Ports: clk_i, rst_i, push, pop, flush, wdata in; rdata (head sample), level, full, empty out.
// Callers must not push when full nor pop when empty; flush overrides push and pop.
module aud_pwm_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr, rptr;
    // Pointers carry one extra wrap bit so a full FIFO differs from an empty one.
    assign level = wptr - rptr;
    assign full  = level == (AW+1)'(DEPTH);
    assign empty = level == '0;
    assign rdata = mem[rptr[AW-1:0]];
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            rptr <= wptr;
        end else begin
            wptr <= push ? wptr + 1'b1 : wptr;
            rptr <= pop ? rptr + 1'b1 : rptr;
        end
    end
    always_ff @(posedge clk_i)
        if (push && !flush) mem[wptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/apb_aud_pwm.sv
// apb_aud_pwm: APB completer buffering 8-bit audio samples and playing them as PWM, one sample per frame
// Ports: clk_i, rst_i (sync, active-high); bus (APB slave modport); pwm_o (PWM audio); irq_o (FIFO watermark irq).
module apb_aud_pwm
    import aud_pwm_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int APB_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    apb_aud_pwm_if.slave    bus,
    output logic            pwm_o,
    output logic            irq_o
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    ctrl_reg_t   ctrl, ctrl_n;
    logic [15:0] div, div_n, pre, pre_n;
    logic [7:0]  duty, duty_n, cnt, cnt_n, fifo_rdata, level8;
    logic [LW-1:0] level;
    logic [2:0]  off;
    logic [31:0] rd;
    logic xfer, wr, push, pop, flush, clr, run, tick, frame_end, full, empty, underrun, underrun_n;
    logic unused;
    assign unused = ^{bus.paddr[APB_ADDR_WIDTH-1:5], bus.paddr[1:0], bus.pwdata[APB_DATA_WIDTH-1:16]};
    assign xfer   = bus.psel & bus.penable;
    assign wr     = xfer & bus.pwrite;
    assign off    = bus.paddr[4:2];
    assign level8 = 8'(level);
    assign push   = wr & (off == OFF_DATA) & ~full;
    assign flush  = wr & (off == OFF_CTRL) & bus.pwdata[CTRL_FLUSH];
    assign clr    = wr & (off == OFF_STAT) & bus.pwdata[STAT_UNDERRUN];
    assign ctrl_n = (wr && off == OFF_CTRL)
                  ? ctrl_reg_t'({bus.pwdata[CTRL_WMARK+:8], bus.pwdata[CTRL_IRQ_EN], bus.pwdata[CTRL_EN]})
                  : ctrl;
    assign div_n  = (wr && off == OFF_DIV) ? bus.pwdata[15:0] : div;
    // Counting needs EN both before and after the edge, so clearing EN zeroes the counters immediately.
    assign run       = ctrl.en & ctrl_n.en;
    assign tick      = run & (pre == div);
    assign frame_end = tick & (cnt == 8'hff);
    assign pop       = frame_end & ~empty & ~flush;
    assign pre_n     = (run && !tick) ? pre + 16'd1 : '0;
    assign cnt_n     = run ? cnt + {7'b0, tick} : '0;
    assign duty_n    = pop ? fifo_rdata : duty;
    assign underrun_n = (frame_end & empty) | (underrun & ~clr);
    assign rd = off == OFF_CTRL ? {16'b0, ctrl.wmark, 5'b0, 1'b0, ctrl.irq_en, ctrl.en}
              : off == OFF_DIV  ? {16'b0, div}
              : off == OFF_STAT ? {21'b0, underrun, full, empty, level8}
              : off == OFF_DUTY ? {24'b0, duty}
              : 32'b0;
    assign bus.prdata  = (xfer && !bus.pwrite) ? APB_DATA_WIDTH'(rd) : '0;
    assign bus.pslverr = xfer & ((off > OFF_DUTY) | (bus.pwrite & (off == OFF_DATA) & full));
    assign bus.pready  = 1'b1;
    aud_pwm_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (bus.pwdata[7:0]),
        .rdata (fifo_rdata),
        .level (level),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl     <= '0;
            div      <= '0;
            duty     <= DUTY_RESET;
            pre      <= '0;
            cnt      <= '0;
            underrun <= 1'b0;
            pwm_o    <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            ctrl     <= ctrl_n;
            div      <= div_n;
            duty     <= duty_n;
            pre      <= pre_n;
            cnt      <= cnt_n;
            underrun <= underrun_n;
            pwm_o    <= ctrl_n.en & (cnt_n < duty_n);
            irq_o    <= ctrl.irq_en & ctrl.en & (level8 <= ctrl.wmark);
        end
    end
endmodule

// File: tb/tb_apb_aud_pwm.sv
// tb_apb_aud_pwm: randomized scoreboard bench for apb_aud_pwm against a sample-queue reference model
module tb_apb_aud_pwm;
    import aud_pwm_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pwm, irq;
    apb_aud_pwm_if #(.AW(12), .DW(32)) bus();
    apb_aud_pwm #(.APB_ADDR_WIDTH(12), .APB_DATA_WIDTH(32), .FIFO_DEPTH(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus),
        .pwm_o (pwm),
        .irq_o (irq)
    );
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit          rd;
        logic [2:0]  off;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    bit          m_en, m_irq_en, m_und, m_pwm, m_irq;
    logic [7:0]  m_wmark, m_duty;
    logic [15:0] m_div;
    logic [7:0]  m_q[$];
    longint      m_ecnt;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_en = 0; m_irq_en = 0; m_und = 0; m_pwm = 0; m_irq = 0;
        m_wmark = 0; m_duty = 8'h80; m_div = 0; m_ecnt = 0;
        m_q.delete();
    endfunction

    // Counter position and prescale phase follow from the count of enabled clocks.
    function automatic int frame_pos(longint e, logic [15:0] dv);
        return int'((e / (longint'(dv) + 1)) % 256);
    endfunction

    function automatic void model_update();
        bit x, w, ne, ni, flush, clr, push, run, fe, empty, full;
        logic [7:0]  nwm;
        logic [15:0] ndiv;
        logic [31:0] d;
        logic [2:0]  off;
        if (rst) begin
            model_reset();
            return;
        end
        x = bus.psel && bus.penable; w = bus.pwrite; d = bus.pwdata; off = bus.paddr[4:2];
        empty = m_q.size() == 0; full = m_q.size() == 16;
        m_irq = m_irq_en && m_en && (m_q.size() <= int'(m_wmark));
        ne = m_en; ni = m_irq_en; nwm = m_wmark; ndiv = m_div;
        flush = 0; clr = 0; push = 0;
        if (x && w) begin
            if (off == 0) begin ne = d[0]; ni = d[1]; nwm = d[15:8]; flush = d[2]; end
            if (off == 1) ndiv = d[15:0];
            if (off == 2) push = !full;
            if (off == 3) clr = d[10];
        end
        run = m_en && ne;
        fe = run && ((m_ecnt % (longint'(m_div) + 1)) == longint'(m_div)) && frame_pos(m_ecnt, m_div) == 255;
        if (fe && empty) m_und = 1;
        else if (clr) m_und = 0;
        if (fe && !empty && !flush) m_duty = m_q.pop_front();
        if (push) m_q.push_back(d[7:0]);
        if (flush) m_q.delete();
        m_ecnt = run ? m_ecnt + 1 : 0;
        m_en = ne; m_irq_en = ni; m_wmark = nwm; m_div = ndiv;
        m_pwm = m_en && (frame_pos(m_ecnt, m_div) < int'(m_duty));
    endfunction

    function automatic exp_t expect_resp(bit wr, logic [2:0] off);
        exp_t e;
        bit full, empty;
        full = m_q.size() == 16; empty = m_q.size() == 0;
        e.rd = !wr; e.off = off;
        e.err = (off > 4) || (wr && off == 2 && full);
        e.data = off == 0 ? {16'b0, m_wmark, 5'b0, 1'b0, m_irq_en, m_en}
               : off == 1 ? {16'b0, m_div}
               : off == 3 ? {21'b0, m_und, full, empty, 8'(m_q.size())}
               : off == 4 ? {24'b0, m_duty}
               : 32'b0;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check("pwm_o", 32'(pwm), 32'(m_pwm));
        check("irq_o", 32'(irq), 32'(m_irq));
    endtask

    task automatic run_cycles(int n);
        repeat (n) step();
    endtask

    task automatic apb(bit wr, logic [2:0] off, logic [31:0] d);
        bus.paddr = {7'($urandom), off, 2'b00};
        bus.pwrite = wr; bus.pwdata = d; bus.psel = 1; bus.penable = 0;
        step();
        bus.penable = 1;
        sb.push_back(expect_resp(wr, off));
        step();
        bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
    endtask

    // Monitor: compares every access-phase response with the head of the scoreboard.
    initial forever begin
        exp_t e;
        @(negedge clk);
        #1;
        if (bus.psel && bus.penable) begin
            if (sb.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL apb_unexpected: transfer with empty scoreboard at %0t", $time);
            end else begin
                e = sb.pop_front();
                check($sformatf("pslverr@%0h", e.off), 32'(bus.pslverr), 32'(e.err));
                if (e.rd) check($sformatf("prdata@%0h", e.off), bus.prdata, e.data);
            end
        end else if (bus.psel) begin
            check("setup_prdata", bus.prdata, 0);
            check("setup_pslverr", 32'(bus.pslverr), 0);
        end
    end

    initial begin
        logic [31:0] d;
        model_reset();
        bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0; bus.pwdata = 0;
        run_cycles(3);
        rst = 0;
        apb(0, OFF_STAT, 0);
        apb(0, OFF_DUTY, 0);
        apb(0, OFF_CTRL, 0);
        apb(1, OFF_DATA, 32'h40);
        apb(1, OFF_DIV, 0);
        apb(1, OFF_CTRL, 32'h1);
        run_cycles(600);
        apb(0, OFF_DUTY, 0);
        run_cycles(200);
        apb(0, OFF_STAT, 0);
        apb(1, OFF_STAT, 32'h400);
        apb(0, OFF_STAT, 0);
        apb(1, OFF_CTRL, 0);
        for (int i = 0; i < 17; i++) apb(1, OFF_DATA, $urandom);
        apb(0, OFF_STAT, 0);
        apb(0, 3'd5, 0);
        apb(1, 3'd6, $urandom);
        apb(0, 3'd7, 0);
        apb(1, OFF_CTRL, 32'h4);
        apb(0, OFF_STAT, 0);
        for (int i = 0; i < 5; i++) apb(1, OFF_DATA, $urandom);
        apb(1, OFF_CTRL, 32'h4);
        apb(0, OFF_STAT, 0);
        rst = 1; step(); rst = 0;
        apb(1, OFF_CTRL, 32'h0202);
        for (int i = 0; i < 4; i++) apb(1, OFF_DATA, $urandom);
        apb(1, OFF_DIV, 1);
        apb(1, OFF_CTRL, 32'h0203);
        run_cycles(1100);
        apb(1, OFF_DATA, 32'h11);
        run_cycles(10);
        for (int i = 0; i < 400; i++) begin
            run_cycles($urandom_range(0, 40));
            case ($urandom_range(0, 9))
                0, 1, 2, 3: apb(1, OFF_DATA, $urandom);
                4: begin
                    d = {16'b0, 8'($urandom_range(0, 20)), 5'b0,
                         1'($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom_range(0, 3) != 0)};
                    apb(1, OFF_CTRL, d);
                end
                5: if (!m_en) apb(1, OFF_DIV, $urandom_range(0, 2)); else apb(0, OFF_DIV, 0);
                6: apb(1, OFF_STAT, {21'b0, 1'($urandom), 10'($urandom)});
                7: apb(0, 3'($urandom), 0);
                8: apb(1, 3'($urandom_range(4, 7)), $urandom);
                default: apb(0, OFF_STAT, 0);
            endcase
        end
        apb(1, OFF_DATA, 32'h33);
        apb(1, OFF_CTRL, 32'h0f03);
        run_cycles(100);
        rst = 1; step(); rst = 0;
        run_cycles(2);
        apb(0, OFF_STAT, 0);
        apb(0, OFF_DUTY, 0);
        apb(0, OFF_CTRL, 0);
        run_cycles(3);
        if (sb.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL scoreboard_drain: %0d responses never seen, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
